// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared op codes, FSM states and widths for the MEM-stage load/store unit
package mem_access_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    function automatic logic is_load(mem_op_e op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_sub_store(mem_op_e op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX/MEM, data-memory and MEM/WB signal bundle of the load/store unit
interface mem_access_unit_if;
    import mem_access_pkg::*;

    logic                 in_valid;
    mem_op_e              in_op;
    logic [WORD_W-1:0]    in_addr;
    logic [WORD_W-1:0]    in_wdata;
    logic [REG_IDX_W-1:0] in_rd;
    logic                 in_regwrite;
    logic                 stall;

    logic [WORD_W-1:0]    dm_id;
    logic                 dm_read;
    logic                 dm_write;
    logic [WORD_W-1:0]    dm_wdata;
    logic [WORD_W-1:0]    dm_rdata;

    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 wb_regwrite;
    logic [WORD_W-1:0]    wb_data;
    logic                 wb_fault;
    logic [WORD_W-1:0]    fault_addr;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd, in_regwrite, dm_rdata,
        output stall, dm_id, dm_read, dm_write, dm_wdata,
               wb_valid, wb_rd, wb_regwrite, wb_data, wb_fault, fault_addr
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd, in_regwrite, dm_rdata,
        input  stall, dm_id, dm_read, dm_write, dm_wdata,
               wb_valid, wb_rd, wb_regwrite, wb_data, wb_fault, fault_addr
    );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte/half lane extraction for loads and lane merge for stores
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  mem_op_e           op_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [WORD_W-1:0] shifted;
    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] lane;

    assign byte_sh = {off_i, 3'b000};
    assign half_sh = {off_i[1], 4'b0000};

    always_comb begin
        shifted = word_i >> byte_sh;
        case (op_i)
            OP_LB:   load_o = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_o = {24'h0, shifted[7:0]};
            OP_LH:   load_o = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_o = {16'h0, shifted[15:0]};
            default: load_o = word_i;
        endcase
    end

    // Non-sub-word ops pass wdata through so SW can share the path.
    always_comb begin
        mask    = '0;
        lane    = '0;
        merge_o = wdata_i;
        case (op_i)
            OP_SB: begin
                mask    = 32'h0000_00FF << byte_sh;
                lane    = {24'h0, wdata_i[7:0]} << byte_sh;
                merge_o = (word_i & ~mask) | (lane & mask);
            end
            OP_SH: begin
                mask    = 32'h0000_FFFF << half_sh;
                lane    = {16'h0, wdata_i[15:0]} << half_sh;
                merge_o = (word_i & ~mask) | (lane & mask);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word read-modify-write and fault detection
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 64
)(
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);

    localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH * 4);

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    merge_q, merge_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic                 wb_regwrite_q, wb_regwrite_d;
    logic [WORD_W-1:0]    wb_data_q, wb_data_d;
    logic                 wb_fault_q, wb_fault_d;
    logic [WORD_W-1:0]    fault_addr_q, fault_addr_d;

    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic              access_ok;
    logic              stall_c;
    logic              read_c;
    logic              write_c;
    logic [WORD_W-1:0] wdata_c;
    logic [WORD_W-1:0] load_word;
    logic [WORD_W-1:0] merge_word;

    mem_lane_align u_align (
        .word_i  (bus.dm_rdata),
        .off_i   (bus.in_addr[1:0]),
        .op_i    (bus.in_op),
        .wdata_i (bus.in_wdata),
        .load_o  (load_word),
        .merge_o (merge_word)
    );

    always_comb begin
        case (bus.in_op)
            OP_LH, OP_LHU, OP_SH: misaligned = bus.in_addr[0];
            OP_LW, OP_SW:         misaligned = |bus.in_addr[1:0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (bus.in_addr >= ADDR_LIMIT);
    assign fault        = bus.in_valid && (bus.in_op != OP_NONE) && (misaligned || out_of_range);
    assign access_ok    = bus.in_valid && (bus.in_op != OP_NONE) && !fault;

    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        stall_c       = 1'b0;
        read_c        = 1'b0;
        write_c       = 1'b0;
        wdata_c       = bus.in_wdata;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_data_d     = wb_data_q;
        wb_fault_d    = wb_fault_q;
        fault_addr_d  = fault_addr_q;

        case (state_q)
            IDLE: begin
                if (access_ok && is_sub_store(bus.in_op)) begin
                    read_c        = 1'b1;
                    stall_c       = 1'b1;
                    merge_d       = merge_word;
                    state_d       = MERGE;
                    wb_valid_d    = 1'b0;
                    wb_regwrite_d = 1'b0;
                    wb_fault_d    = 1'b0;
                end else begin
                    read_c        = access_ok && is_load(bus.in_op);
                    write_c       = access_ok && (bus.in_op == OP_SW);
                    wb_valid_d    = bus.in_valid;
                    wb_rd_d       = bus.in_rd;
                    wb_regwrite_d = bus.in_valid && bus.in_regwrite &&
                                    !is_store(bus.in_op) && !fault;
                    wb_fault_d    = fault;
                    if (!bus.in_valid || fault)
                        wb_data_d = '0;
                    else if (is_load(bus.in_op))
                        wb_data_d = load_word;
                    else if (bus.in_op == OP_NONE)
                        wb_data_d = bus.in_addr;
                    else
                        wb_data_d = '0;
                    if (fault)
                        fault_addr_d = bus.in_addr;
                end
            end
            MERGE: begin
                write_c       = 1'b1;
                wdata_c       = merge_q;
                state_d       = IDLE;
                wb_valid_d    = 1'b1;
                wb_rd_d       = bus.in_rd;
                wb_regwrite_d = 1'b0;
                wb_fault_d    = 1'b0;
                wb_data_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            merge_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= '0;
            wb_fault_q    <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            merge_q       <= merge_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_data_q     <= wb_data_d;
            wb_fault_q    <= wb_fault_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    // Gated by rst_n so a reset during MERGE kills the negedge write immediately.
    assign bus.stall       = rst_n && stall_c;
    assign bus.dm_read     = rst_n && read_c;
    assign bus.dm_write    = rst_n && write_c;
    assign bus.dm_wdata    = wdata_c;
    assign bus.dm_id       = {2'b00, bus.in_addr[31:2]};
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_fault    = wb_fault_q;
    assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with randomized ops and a word-array reference model
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign bus.dm_rdata = (bus.dm_id < DEPTH) ? mem[bus.dm_id[5:0]] : 32'h0;

    always @(negedge clk)
        if (bus.dm_write && bus.dm_id < DEPTH) mem[bus.dm_id[5:0]] <= bus.dm_wdata;

    typedef struct {
        logic [4:0]  rd;
        logic        regwrite;
        logic        fault;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] faddr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_faddr = 32'h0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
                chk("wb_regwrite", 32'(bus.wb_regwrite), 32'(mon_e.regwrite));
                chk("wb_fault", 32'(bus.wb_fault), 32'(mon_e.fault));
                chk("fault_addr", bus.fault_addr, mon_e.faddr);
                if (mon_e.chk_data) chk("wb_data", bus.wb_data, mon_e.data);
            end
        end
    end

    // Reference: byte-addressed semantics over a word array, plus the fault rules.
    task automatic model(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw,
                         output exp_t e, output bit st, output bit er, output bit ew);
        bit          flt;
        int          sh;
        logic [31:0] w, b, h, msk;
        flt = 0;
        if (op != 0) begin
            if (addr >= DEPTH * 4) flt = 1;
            if ((op == 2 || op == 5 || op == 7) && addr % 2 != 0) flt = 1;
            if ((op == 3 || op == 8) && addr % 4 != 0) flt = 1;
        end
        sh = 8 * int'(addr % 4);
        e.rd = rd; e.fault = flt; e.chk_data = 0; e.data = 0;
        e.regwrite = rw && !flt && !(op >= 6);
        st = 0; er = 0; ew = 0;
        if (flt) ref_faddr = addr;
        e.faddr = ref_faddr;
        if (op == 0) begin
            e.data = addr; e.chk_data = 1;
        end else if (!flt) begin
            w = ref_mem[addr / 4];
            b = (w >> sh) & 32'hFF;
            h = (w >> sh) & 32'hFFFF;
            case (op)
                1: begin e.data = (b >= 128) ? b - 256 : b; e.chk_data = 1; er = 1; end
                2: begin e.data = (h >= 32768) ? h - 65536 : h; e.chk_data = 1; er = 1; end
                3: begin e.data = w; e.chk_data = 1; er = 1; end
                4: begin e.data = b; e.chk_data = 1; er = 1; end
                5: begin e.data = h; e.chk_data = 1; er = 1; end
                6: begin
                    msk = 32'hFF << sh;
                    ref_mem[addr / 4] = (w & ~msk) | ((wdata & 32'hFF) << sh);
                    st = 1; er = 1;
                end
                7: begin
                    msk = 32'hFFFF << sh;
                    ref_mem[addr / 4] = (w & ~msk) | ((wdata & 32'hFFFF) << sh);
                    st = 1; er = 1;
                end
                default: begin ref_mem[addr / 4] = wdata; ew = 1; end
            endcase
        end
    endtask

    // Called #1 after a posedge; returns #1 after the posedge that completes the op.
    task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw);
        exp_t e;
        bit   st, er, ew, s;
        int   stalls;
        model(op, addr, wdata, rd, rw, e, st, er, ew);
        sb_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_op = mem_op_e'(op[3:0]);
        bus.in_addr = addr;
        bus.in_wdata = wdata;
        bus.in_rd = rd;
        bus.in_regwrite = rw;
        @(negedge clk);
        chk("dm_read", 32'(bus.dm_read), 32'(er));
        chk("dm_write", 32'(bus.dm_write), 32'(ew));
        chk("dm_id", bus.dm_id, addr >> 2);
        s = bus.stall;
        @(posedge clk); #1;
        stalls = 0;
        while (s && stalls < 4) begin
            stalls++;
            @(negedge clk);
            chk("merge_dm_write", 32'(bus.dm_write), 32'd1);
            s = bus.stall;
            @(posedge clk); #1;
        end
        chk("stall_cycles", 32'(stalls), 32'(st));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_op = OP_NONE;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          op, r;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        bus.in_valid = 1'b1;
        bus.in_op = OP_SW;
        bus.in_addr = 32'h10;
        bus.in_wdata = 32'h1;
        bus.in_rd = 5'd0;
        bus.in_regwrite = 1'b0;
        #2;
        chk("rst_dm_write", 32'(bus.dm_write), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_fault_addr", bus.fault_addr, 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8, 32'h10, 32'hDEADBEEF, 5'd1, 1'b0);
        issue(3, 32'h10, 32'h0, 5'd2, 1'b1);
        issue(8, 32'h10, 32'h11223344, 5'd0, 1'b0);
        issue(6, 32'h12, 32'h000000AA, 5'd3, 1'b1);
        issue(4, 32'h12, 32'h0, 5'd4, 1'b1);
        issue(1, 32'h12, 32'h0, 5'd5, 1'b1);
        issue(8, 32'h14, 32'h0, 5'd0, 1'b0);
        issue(7, 32'h16, 32'h00008001, 5'd6, 1'b1);
        issue(2, 32'h16, 32'h0, 5'd7, 1'b1);
        issue(5, 32'h16, 32'h0, 5'd8, 1'b1);
        issue(3, 32'h13, 32'h0, 5'd9, 1'b1);
        issue(3, 32'h100, 32'h0, 5'd10, 1'b1);
        issue(0, 32'h2A, 32'h0, 5'd7, 1'b1);
        issue(8, 32'h20, 32'h55667788, 5'd0, 1'b0);
        idle(1);
        chk("word4", mem[4], 32'h11AA3344);
        chk("word5", mem[5], 32'h80010000);

        bus.in_valid = 1'b1;
        bus.in_op = OP_SB;
        bus.in_addr = 32'h21;
        bus.in_wdata = 32'hCC;
        bus.in_rd = 5'd3;
        bus.in_regwrite = 1'b1;
        @(negedge clk);
        chk("rst_sb_stall", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        chk("rst_merge_write", 32'(bus.dm_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_write", 32'(bus.dm_write), 32'd0);
        chk("rst_drop_stall", 32'(bus.stall), 32'd0);
        chk("rst_wb_valid2", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
        chk("rst_wb_fault", 32'(bus.wb_fault), 32'd0);
        chk("rst_fault_addr2", bus.fault_addr, 32'd0);
        ref_faddr = 32'h0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_word8", mem[8], 32'h55667788);
        issue(3, 32'h20, 32'h0, 5'd11, 1'b1);

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 8));
            r = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom_range(256, 511);
            else if (r == 1) a = $urandom;
            else begin
                a = $urandom_range(0, 255);
                if (r > 3) begin
                    if (op == 2 || op == 5 || op == 7) a[0] = 1'b0;
                    if (op == 3 || op == 8) a[1:0] = 2'b00;
                end
            end
            issue(op, a, $urandom, 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
